// File: rtl/reset_sequencer.sv
// reset_sequencer: stretched board reset with staggered per-domain release and software reset.
// Optional watchdog-triggered reset is compiled in when RESET_SEQ_WDT_EN is defined.

module reset_sequencer_checker #(
  parameter int NUM_DOMAINS = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic [NUM_DOMAINS-1:0] rst_vec,
  input logic [NUM_DOMAINS-1:0] nrst_vec,
  input logic                   done,
  input logic [1:0]             cause,
  input logic                   ack
);

  a_nrst_inverse: assert property (@(posedge clk) disable iff (rst) nrst_vec == ~rst_vec);

  a_done_released: assert property (@(posedge clk) disable iff (rst) done |-> (rst_vec == '0));

  a_ack_single: assert property (@(posedge clk) disable iff (rst) ack |=> !ack);

  a_cause_valid: assert property (@(posedge clk) disable iff (rst) cause != 2'b00);

`ifndef RESET_SEQ_WDT_EN
  a_no_wdt_cause: assert property (@(posedge clk) disable iff (rst) cause != 2'b11);
`endif

endmodule

module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int WDT_WIDTH   = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  output logic                   clk_i,
  output logic [NUM_DOMAINS-1:0] rst_i,
  output logic [NUM_DOMAINS-1:0] nrst_i,
  output logic                   rst_done_o,
  output logic [1:0]             rst_cause_o,
  input  logic                   sw_rst_req_i,
  output logic                   sw_rst_ack_o,
  input  logic                   wdt_kick_i
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [1:0]             sync_r;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [IW-1:0]          idx_r, idx_s;
  logic [NUM_DOMAINS-1:0] rst_r, rst_s;
  logic                   done_r, done_s;
  logic [1:0]             cause_r, cause_s;
  logic                   ack_r, ack_s;

`ifdef RESET_SEQ_WDT_EN
  logic [WDT_WIDTH-1:0]   wdt_r, wdt_s;
  logic                   wdt_expire_s;
`else
  logic [WDT_WIDTH-1:0]   unused_wdt_s;
  assign unused_wdt_s = {WDT_WIDTH{wdt_kick_i}};
`endif

  // Two-flop release synchroniser; assertion bypasses it asynchronously.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

`ifdef RESET_SEQ_WDT_EN
  // Watchdog counter only runs while all domains are released.
  always_comb begin
    if ((state_r != ST_RUN) || wdt_kick_i) begin
      wdt_s = '0;
    end else begin
      wdt_s = wdt_r + WDT_WIDTH'(1);
    end
    wdt_expire_s = (wdt_r == {WDT_WIDTH{1'b1}}) && !wdt_kick_i;
  end

  // Watchdog counter register.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      wdt_r <= '0;
    end else begin
      wdt_r <= wdt_s;
    end
  end
`endif

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    rst_s   = rst_r;
    done_s  = done_r;
    cause_s = cause_r;
    ack_s   = 1'b0;
    case (state_r)
      ST_ASSERT: begin
        if (sync_r[1]) begin
          if (cnt_r == CW'(HOLD_CYCLES - 1)) begin
            rst_s[0] = 1'b0;
            cnt_s    = '0;
            idx_s    = IW'(1);
            if (NUM_DOMAINS == 1) begin
              state_s = ST_RUN;
              done_s  = 1'b1;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RELEASE: begin
        if (cnt_r == CW'(STAGGER - 1)) begin
          rst_s = rst_r & ~(NUM_DOMAINS'(1) << idx_r);
          cnt_s = '0;
          if (idx_r == IW'(NUM_DOMAINS - 1)) begin
            state_s = ST_RUN;
            done_s  = 1'b1;
            idx_s   = '0;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_RUN: begin
        // A software request wins over a watchdog expiry in the same cycle.
        if (sw_rst_req_i) begin
          ack_s   = 1'b1;
          rst_s   = '1;
          done_s  = 1'b0;
          cause_s = CAUSE_SW;
          cnt_s   = '0;
          idx_s   = '0;
          state_s = ST_ASSERT;
        end
`ifdef RESET_SEQ_WDT_EN
        else if (wdt_expire_s) begin
          rst_s   = '1;
          done_s  = 1'b0;
          cause_s = CAUSE_WDT;
          cnt_s   = '0;
          idx_s   = '0;
          state_s = ST_ASSERT;
        end
`endif
        else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_ASSERT;
        rst_s   = '1;
        done_s  = 1'b0;
        cnt_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_r <= ST_ASSERT;
      cnt_r   <= '0;
      idx_r   <= '0;
      rst_r   <= '1;
      done_r  <= 1'b0;
      cause_r <= CAUSE_POR;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      rst_r   <= rst_s;
      done_r  <= done_s;
      cause_r <= cause_s;
      ack_r   <= ack_s;
    end
  end

  assign clk_i        = clk_sys_i;
  assign rst_i        = rst_r;
  assign nrst_i       = ~rst_r;
  assign rst_done_o   = done_r;
  assign rst_cause_o  = cause_r;
  assign sw_rst_ack_o = ack_r;

  reset_sequencer_checker #(.NUM_DOMAINS(NUM_DOMAINS)) u_checker (
    .clk      (clk_sys_i),
    .rst      (rst_sys_i),
    .rst_vec  (rst_r),
    .nrst_vec (nrst_i),
    .done     (done_r),
    .cause    (cause_r),
    .ack      (ack_r)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-domain instance plus a 1-domain instance.
// Covers the watchdog path when built with RESET_SEQ_WDT_EN.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_sys = 1'b1;
  logic       sw_req = 1'b0;
  logic       kick = 1'b0;
  logic       clk_out, clk_out1;
  logic [3:0] rst_v, nrst_v;
  logic       done_v, ack_v;
  logic [1:0] cause_v;
  logic [0:0] rst1_v, nrst1_v;
  logic       done1_v, ack1_v;
  logic [1:0] cause1_v;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(16), .STAGGER(4), .WDT_WIDTH(4)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst_sys), .clk_i(clk_out), .rst_i(rst_v), .nrst_i(nrst_v),
    .rst_done_o(done_v), .rst_cause_o(cause_v), .sw_rst_req_i(sw_req),
    .sw_rst_ack_o(ack_v), .wdt_kick_i(kick)
  );

  reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER(1), .WDT_WIDTH(16)) dut1 (
    .clk_sys_i(clk), .rst_sys_i(rst_sys), .clk_i(clk_out1), .rst_i(rst1_v), .nrst_i(nrst1_v),
    .rst_done_o(done1_v), .rst_cause_o(cause1_v), .sw_rst_req_i(1'b0),
    .sw_rst_ack_o(ack1_v), .wdt_kick_i(1'b0)
  );

  typedef struct {
    int         e;
    logic [3:0] rst;
    logic       done;
    logic       rst1;
    logic       done1;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic check_main(input string name, input logic [3:0] r, input logic d,
                            input logic [1:0] c, input logic a);
    check({name, "_rst"}, {28'd0, rst_v}, {28'd0, r});
    check({name, "_nrst"}, {28'd0, nrst_v}, {28'd0, ~r});
    check({name, "_done"}, {31'd0, done_v}, {31'd0, d});
    check({name, "_cause"}, {30'd0, cause_v}, {30'd0, c});
    check({name, "_ack"}, {31'd0, ack_v}, {31'd0, a});
  endtask

  task automatic power_on();
    rst_sys = 1'b1;
    tick();
    tick();
    check_main("reset_state", 4'hF, 1'b0, 2'b01, 1'b0);
    check("reset_state_d1", {30'd0, rst1_v, done1_v}, 32'h2);
    rst_sys = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_table(input string name, input logic [1:0] cause_exp);
    for (int i = 0; i < 11; i++) begin
      tick_to(tbl[i].e);
      check_main(name, tbl[i].rst, tbl[i].done, cause_exp, 1'b0);
      check({name, "_d1"}, {30'd0, rst1_v, done1_v}, {30'd0, tbl[i].rst1, tbl[i].done1});
    end
  endtask

  initial begin
    int bad;
    tbl[0]  = '{1,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{2,  4'hF, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{3,  4'hF, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{17, 4'hF, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{18, 4'hE, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{21, 4'hE, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{22, 4'hC, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{25, 4'hC, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{26, 4'h8, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{29, 4'h8, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{30, 4'h0, 1'b1, 1'b0, 1'b1};

    // Power-on sequence.
    power_on();
    run_table("por", 2'b01);

    // Software reset accepted at edge 35.
    tick_to(34);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check_main("sw_accept", 4'hF, 1'b0, 2'b10, 1'b1);
    tick();
    check_main("sw_ack_end", 4'hF, 1'b0, 2'b10, 1'b0);
    tick_to(50);
    check_main("sw_hold", 4'hF, 1'b0, 2'b10, 1'b0);
    tick_to(51);
    check_main("sw_rel0", 4'hE, 1'b0, 2'b10, 1'b0);
    tick_to(55);
    check_main("sw_rel1", 4'hC, 1'b0, 2'b10, 1'b0);
    tick_to(63);
    check_main("sw_run", 4'h0, 1'b1, 2'b10, 1'b0);

    // Asynchronous board reset in the middle of RELEASE.
    power_on();
    tick_to(24);
    check_main("mid_release", 4'hC, 1'b0, 2'b01, 1'b0);
    #2;
    rst_sys = 1'b1;
    #1;
    check_main("async_assert", 4'hF, 1'b0, 2'b01, 1'b0);
    power_on();
    run_table("restart", 2'b01);

    // Software request held across power-on release.
    sw_req = 1'b1;
    power_on();
    run_table("held_req", 2'b01);
    tick_to(31);
    check_main("held_accept", 4'hF, 1'b0, 2'b10, 1'b1);
    sw_req = 1'b0;
    tick();
    check_main("held_ack_end", 4'hF, 1'b0, 2'b10, 1'b0);
    tick_to(59);
    check_main("held_run", 4'h0, 1'b1, 2'b10, 1'b0);

`ifdef RESET_SEQ_WDT_EN
    // Watchdog expiry with no kicks: RUN at 59, trigger at 59+16.
    tick_to(74);
    check_main("wdt_pre", 4'h0, 1'b1, 2'b10, 1'b0);
    tick_to(75);
    check_main("wdt_fire", 4'hF, 1'b0, 2'b11, 1'b0);
    tick_to(103);
    check_main("wdt_run", 4'h0, 1'b1, 2'b11, 1'b0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      kick = (i % 10 == 0);
      tick();
      if (done_v !== 1'b1) bad++;
    end
    kick = 1'b0;
    check("wdt_kicked_no_reset", bad, 0);
    check("wdt_kicked_cause", {30'd0, cause_v}, 32'h3);
`else
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_v !== 1'b1) bad++;
    end
    check("no_wdt_stays_run", bad, 0);
    check("no_wdt_cause", {30'd0, cause_v}, 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
